// File: rtl/data_mem_responder_pkg.sv
// dmem_pkg: shared widths, depth and FSM state type for the data-memory responder
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH = 128;
  typedef enum logic {ST_CLEAR, ST_READY} dmem_state_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: core-side data-memory strobes, address, data and status
interface data_mem_responder_if;
  import dmem_pkg::*;
  logic CEN;
  logic WEN;
  logic OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Data2Mem;
  logic [DATA_W-1:0] ReadDataMem;
  logic mem_ready;
  logic access_err;
  modport master (output CEN, WEN, OEN, A, Data2Mem, input ReadDataMem, mem_ready, access_err);
  modport slave (input CEN, WEN, OEN, A, Data2Mem, output ReadDataMem, mem_ready, access_err);
endinterface

// File: rtl/data_mem_responder_array.sv
// dmem_array: word storage with one synchronous write port and one asynchronous read port
module dmem_array
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data RAM for the core with zero-fill after reset and sticky protocol-error flag
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int READ_LAT = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  dmem_state_t state, state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] rdata;
  logic ready, clearing, in_range, wr, err;
  assign ready = state == ST_READY;
  assign clearing = state == ST_CLEAR;
  assign in_range = {1'b0, bus.A} < DEPTH_L;
  assign wr = ~bus.CEN & ~bus.WEN;
  // any enabled access while clearing, out of range, or with both strobes low is a protocol error
  assign err = ~bus.CEN & (clearing | ~in_range | (~bus.WEN & ~bus.OEN));
  assign bus.mem_ready = ready;
  always_comb state_nx = (clearing && clr_ptr == LAST) ? ST_READY : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_READY;
      clr_ptr <= '0;
      bus.access_err <= 1'b0;
    end else begin
      state <= state_nx;
      clr_ptr <= clearing ? clr_ptr + 1'b1 : clr_ptr;
      bus.access_err <= bus.access_err | err;
    end
  end
  dmem_array u_array (
    .clk  (clk),
    .we   (clearing | (ready & wr & in_range)),
    .waddr(clearing ? clr_ptr : bus.A),
    .wdata(clearing ? '0 : bus.Data2Mem),
    .raddr(bus.A),
    .rdata(rdata)
  );
  if (READ_LAT == 0) begin : g_comb
    logic rd;
    assign rd = ~bus.CEN & ~bus.OEN & bus.WEN;
    assign bus.ReadDataMem = (ready & rd & in_range) ? rdata : '0;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_q;
    // conflict cycles also load, capturing the pre-write word
    always_ff @(posedge clk)
      if (rst) rd_q <= '0;
      else if (~bus.CEN & ~bus.OEN) rd_q <= (ready & in_range) ? rdata : '0;
    assign bus.ReadDataMem = rd_q;
  end
endmodule
